// File: rtl/ransac_status_aggregator.sv
// Aggregates per-iteration statuses from parallel plane checking units into per-class
// counts, tracks completed iterations and decides when a RANSAC run ends.
module ransac_status_aggregator #(
    parameter int NUM_UNITS = 4,
    parameter int ITER_W    = 32,
    parameter int CNT_W     = 16,
    parameter int ERR_LIMIT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [ITER_W-1:0]      iterations_i,
    input  logic                   abort_i,
    input  logic [NUM_UNITS-1:0]   unit_done_i,
    input  logic [2*NUM_UNITS-1:0] unit_status_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   aborted_o,
    output logic [31:0]            status_o,
    output logic [ITER_W-1:0]      completed_o,
    output logic [CNT_W-1:0]       success_cnt_o,
    output logic [CNT_W-1:0]       derive_err_cnt_o,
    output logic [CNT_W-1:0]       bus_err_cnt_o,
    output logic [CNT_W-1:0]       timeout_cnt_o
);

    localparam int INC_W = $clog2(NUM_UNITS + 1);

    localparam logic [1:0] PCU_SUCCESS = 2'd0;
    localparam logic [1:0] PCU_DERIVE  = 2'd1;
    localparam logic [1:0] PCU_BUS     = 2'd2;
    localparam logic [1:0] PCU_TIMEOUT = 2'd3;

    typedef enum logic [31:0] {
        IDLE_WITHOUT_ERROR             = 32'd0,
        RUNNING                        = 32'd1,
        IDLE_AFTER_DERIVE_PLANE_ERRORS = 32'd2,
        IDLE_AFTER_BUS_ERRORS          = 32'd3,
        IDLE_AFTER_BUS_TIMEOUTS        = 32'd4
    } ransac_unit_status_e;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e            state;
    logic [ITER_W-1:0] target;
    logic [ITER_W-1:0] err_total;

    logic [ITER_W-1:0] remaining;
    logic [ITER_W-1:0] acc;
    logic [INC_W-1:0]  inc_s, inc_d, inc_b, inc_t;
    logic [CNT_W-1:0]  succ_next, der_next, bus_next, to_next;
    logic [ITER_W-1:0] err_next;
    logic              reach, err_hit;
    logic [31:0]       final_status;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [INC_W-1:0] b);
        logic [CNT_W+INC_W-1:0] s;
        s = {{INC_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
        if (s[CNT_W+INC_W-1:CNT_W] != '0) return '1;
        return s[CNT_W-1:0];
    endfunction

    // Completions are granted lowest index first until the target is met; later bits drop.
    always_comb begin
        remaining = target - completed_o;
        acc   = '0;
        inc_s = '0;
        inc_d = '0;
        inc_b = '0;
        inc_t = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (unit_done_i[k] && (acc < remaining)) begin
                acc = acc + 1'b1;
                case (unit_status_i[2*k +: 2])
                    PCU_SUCCESS: inc_s = inc_s + 1'b1;
                    PCU_DERIVE:  inc_d = inc_d + 1'b1;
                    PCU_BUS:     inc_b = inc_b + 1'b1;
                    default:     inc_t = inc_t + 1'b1;
                endcase
            end
        end
        succ_next = sat_add(success_cnt_o, inc_s);
        der_next  = sat_add(derive_err_cnt_o, inc_d);
        bus_next  = sat_add(bus_err_cnt_o, inc_b);
        to_next   = sat_add(timeout_cnt_o, inc_t);
        err_next  = err_total + ITER_W'(inc_d) + ITER_W'(inc_b) + ITER_W'(inc_t);
        reach     = ((completed_o + acc) == target);
        err_hit   = (ERR_LIMIT != 0) && (err_next >= ITER_W'(ERR_LIMIT));
        if (to_next != '0)       final_status = IDLE_AFTER_BUS_TIMEOUTS;
        else if (bus_next != '0) final_status = IDLE_AFTER_BUS_ERRORS;
        else if (der_next != '0) final_status = IDLE_AFTER_DERIVE_PLANE_ERRORS;
        else                     final_status = IDLE_WITHOUT_ERROR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            target           <= '0;
            err_total        <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            aborted_o        <= 1'b0;
            status_o         <= IDLE_WITHOUT_ERROR;
            completed_o      <= '0;
            success_cnt_o    <= '0;
            derive_err_cnt_o <= '0;
            bus_err_cnt_o    <= '0;
            timeout_cnt_o    <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        target           <= iterations_i;
                        err_total        <= '0;
                        aborted_o        <= 1'b0;
                        completed_o      <= '0;
                        success_cnt_o    <= '0;
                        derive_err_cnt_o <= '0;
                        bus_err_cnt_o    <= '0;
                        timeout_cnt_o    <= '0;
                        if (iterations_i != '0) begin
                            state    <= S_RUN;
                            busy_o   <= 1'b1;
                            status_o <= RUNNING;
                        end else begin
                            done_o   <= 1'b1;
                            status_o <= IDLE_WITHOUT_ERROR;
                        end
                    end
                end
                default: begin
                    completed_o      <= completed_o + acc;
                    success_cnt_o    <= succ_next;
                    derive_err_cnt_o <= der_next;
                    bus_err_cnt_o    <= bus_next;
                    timeout_cnt_o    <= to_next;
                    err_total        <= err_next;
                    // Reaching the target wins over abort or error limit for aborted_o.
                    if (reach || abort_i || err_hit) begin
                        state     <= S_IDLE;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        aborted_o <= !reach;
                        status_o  <= final_status;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ransac_status_aggregator.sv
// Directed bench for ransac_status_aggregator: one default instance and one with
// ERR_LIMIT=2 / CNT_W=2 for error-limit and saturation scenarios.
module tb_ransac_status_aggregator;

    localparam logic [31:0] ST_IDLE_OK  = 32'd0;
    localparam logic [31:0] ST_RUNNING  = 32'd1;
    localparam logic [31:0] ST_DERIVE   = 32'd2;
    localparam logic [31:0] ST_BUS      = 32'd3;
    localparam logic [31:0] ST_TIMEOUT  = 32'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          errors = 0;
    int          checks = 0;

    logic        start = 1'b0, abort = 1'b0;
    logic [31:0] iterations = '0;
    logic [3:0]  unit_done = '0;
    logic [7:0]  unit_status = '0;
    logic        busy, done, aborted;
    logic [31:0] status, completed;
    logic [15:0] succ, der, bus, tmo;

    logic        e_start = 1'b0, e_abort = 1'b0;
    logic [31:0] e_iterations = '0;
    logic [3:0]  e_unit_done = '0;
    logic [7:0]  e_unit_status = '0;
    logic        e_busy, e_done, e_aborted;
    logic [31:0] e_status, e_completed;
    logic [1:0]  e_succ, e_der, e_bus, e_tmo;

    always #5 clk = ~clk;

    ransac_status_aggregator dut (
        .clk(clk), .rst(rst), .start_i(start), .iterations_i(iterations), .abort_i(abort),
        .unit_done_i(unit_done), .unit_status_i(unit_status), .busy_o(busy), .done_o(done),
        .aborted_o(aborted), .status_o(status), .completed_o(completed),
        .success_cnt_o(succ), .derive_err_cnt_o(der), .bus_err_cnt_o(bus), .timeout_cnt_o(tmo)
    );

    ransac_status_aggregator #(.NUM_UNITS(4), .ITER_W(32), .CNT_W(2), .ERR_LIMIT(2)) dut_e (
        .clk(clk), .rst(rst), .start_i(e_start), .iterations_i(e_iterations), .abort_i(e_abort),
        .unit_done_i(e_unit_done), .unit_status_i(e_unit_status), .busy_o(e_busy), .done_o(e_done),
        .aborted_o(e_aborted), .status_o(e_status), .completed_o(e_completed),
        .success_cnt_o(e_succ), .derive_err_cnt_o(e_der), .bus_err_cnt_o(e_bus), .timeout_cnt_o(e_tmo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0d want 0", done); end
        checks++; if (status !== ST_IDLE_OK) begin errors++; $display("FAIL reset_status: got %0d want %0d", status, ST_IDLE_OK); end
        checks++; if ({completed, succ, der, bus, tmo} !== '0) begin errors++; $display("FAIL reset_counts: got %0h want 0", {completed, succ, der, bus, tmo}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_success();
        start = 1'b1; iterations = 32'd8;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || status !== ST_RUNNING) begin errors++; $display("FAIL run_start: got busy=%0d status=%0d want busy=1 status=%0d", busy, status, ST_RUNNING); end
        unit_done = 4'hF; unit_status = 8'h00;
        tick();
        checks++; if (completed !== 32'd4 || done !== 1'b0) begin errors++; $display("FAIL full_first: got completed=%0d done=%0d want 4/0", completed, done); end
        tick();
        unit_done = 4'h0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL full_end: got done=%0d busy=%0d want 1/0", done, busy); end
        checks++; if (succ !== 16'd8 || completed !== 32'd8) begin errors++; $display("FAIL full_counts: got succ=%0d completed=%0d want 8/8", succ, completed); end
        checks++; if (status !== ST_IDLE_OK || aborted !== 1'b0) begin errors++; $display("FAIL full_status: got status=%0d aborted=%0d want %0d/0", status, aborted, ST_IDLE_OK); end
        tick();
        checks++; if (done !== 1'b0 || succ !== 16'd8) begin errors++; $display("FAIL full_hold: got done=%0d succ=%0d want 0/8", done, succ); end
    endtask

    task automatic test_excess_drop();
        start = 1'b1; iterations = 32'd3;
        tick();
        start = 1'b0;
        unit_done = 4'hF; unit_status = 8'hE4;
        tick();
        unit_done = 4'h0; unit_status = 8'h00;
        checks++; if (completed !== 32'd3 || done !== 1'b1) begin errors++; $display("FAIL excess_completed: got completed=%0d done=%0d want 3/1", completed, done); end
        checks++; if ({succ, der, bus, tmo} !== {16'd1, 16'd1, 16'd1, 16'd0}) begin errors++; $display("FAIL excess_counts: got %0d/%0d/%0d/%0d want 1/1/1/0", succ, der, bus, tmo); end
        checks++; if (status !== ST_BUS || aborted !== 1'b0) begin errors++; $display("FAIL excess_status: got status=%0d aborted=%0d want %0d/0", status, aborted, ST_BUS); end
        tick();
    endtask

    task automatic test_abort();
        start = 1'b1; iterations = 32'd10;
        tick();
        start = 1'b0;
        unit_done = 4'hF; unit_status = 8'h00;
        tick();
        unit_done = 4'h1;
        tick();
        checks++; if (completed !== 32'd5 || busy !== 1'b1) begin errors++; $display("FAIL abort_pre: got completed=%0d busy=%0d want 5/1", completed, busy); end
        unit_done = 4'h1; unit_status = 8'h03; abort = 1'b1;
        tick();
        unit_done = 4'h0; unit_status = 8'h00; abort = 1'b0;
        checks++; if (completed !== 32'd6 || tmo !== 16'd1) begin errors++; $display("FAIL abort_counts: got completed=%0d timeout=%0d want 6/1", completed, tmo); end
        checks++; if (aborted !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_flags: got aborted=%0d done=%0d busy=%0d want 1/1/0", aborted, done, busy); end
        checks++; if (status !== ST_TIMEOUT) begin errors++; $display("FAIL abort_status: got %0d want %0d", status, ST_TIMEOUT); end
        unit_done = 4'hF;
        tick();
        unit_done = 4'h0;
        checks++; if (completed !== 32'd6 || succ !== 16'd5) begin errors++; $display("FAIL idle_ignore: got completed=%0d succ=%0d want 6/5", completed, succ); end
    endtask

    task automatic test_zero_target();
        start = 1'b1; iterations = 32'd0;
        tick();
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_pulse: got done=%0d busy=%0d want 1/0", done, busy); end
        checks++; if ({completed, succ, der, bus, tmo} !== '0 || aborted !== 1'b0) begin errors++; $display("FAIL zero_clear: got %0h aborted=%0d want 0/0", {completed, succ, der, bus, tmo}, aborted); end
        checks++; if (status !== ST_IDLE_OK) begin errors++; $display("FAIL zero_status: got %0d want %0d", status, ST_IDLE_OK); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%0d busy=%0d want 0/0", done, busy); end
    endtask

    task automatic test_start_in_run();
        start = 1'b1; iterations = 32'd4;
        tick();
        start = 1'b1; iterations = 32'd2; unit_done = 4'h3; unit_status = 8'h00;
        tick();
        start = 1'b0;
        checks++; if (completed !== 32'd2 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL restart_ignored: got completed=%0d busy=%0d done=%0d want 2/1/0", completed, busy, done); end
        tick();
        unit_done = 4'h0;
        checks++; if (completed !== 32'd4 || done !== 1'b1) begin errors++; $display("FAIL restart_end: got completed=%0d done=%0d want 4/1", completed, done); end
        tick();
    endtask

    task automatic test_err_limit();
        e_start = 1'b1; e_iterations = 32'd100;
        tick();
        e_start = 1'b0;
        e_unit_done = 4'h2; e_unit_status = 8'h04;
        tick();
        e_unit_done = 4'h0;
        checks++; if (e_der !== 2'd1 || e_busy !== 1'b1 || e_done !== 1'b0) begin errors++; $display("FAIL errlim_first: got der=%0d busy=%0d done=%0d want 1/1/0", e_der, e_busy, e_done); end
        tick();
        e_unit_done = 4'h2;
        tick();
        e_unit_done = 4'h0; e_unit_status = 8'h00;
        checks++; if (e_done !== 1'b1 || e_busy !== 1'b0 || e_aborted !== 1'b1) begin errors++; $display("FAIL errlim_end: got done=%0d busy=%0d aborted=%0d want 1/0/1", e_done, e_busy, e_aborted); end
        checks++; if (e_der !== 2'd2 || e_status !== ST_DERIVE || e_completed !== 32'd2) begin errors++; $display("FAIL errlim_status: got der=%0d status=%0d completed=%0d want 2/%0d/2", e_der, e_status, e_completed, ST_DERIVE); end
        tick();
    endtask

    task automatic test_saturation();
        e_start = 1'b1; e_iterations = 32'd10;
        tick();
        e_start = 1'b0;
        e_unit_done = 4'hF; e_unit_status = 8'h00;
        tick();
        checks++; if (e_succ !== 2'd3 || e_completed !== 32'd4) begin errors++; $display("FAIL sat_first: got succ=%0d completed=%0d want 3/4", e_succ, e_completed); end
        tick();
        e_unit_done = 4'h0;
        checks++; if (e_succ !== 2'd3 || e_completed !== 32'd8 || e_busy !== 1'b1) begin errors++; $display("FAIL sat_hold: got succ=%0d completed=%0d busy=%0d want 3/8/1", e_succ, e_completed, e_busy); end
        e_abort = 1'b1;
        tick();
        e_abort = 1'b0;
        checks++; if (e_aborted !== 1'b1 || e_done !== 1'b1 || e_status !== ST_IDLE_OK) begin errors++; $display("FAIL sat_abort: got aborted=%0d done=%0d status=%0d want 1/1/0", e_aborted, e_done, e_status); end
        tick();
    endtask

    task automatic test_async_reset();
        start = 1'b1; iterations = 32'd50;
        tick();
        start = 1'b0;
        unit_done = 4'hF; unit_status = 8'h00;
        tick();
        checks++; if (completed !== 32'd4 || busy !== 1'b1) begin errors++; $display("FAIL arst_pre: got completed=%0d busy=%0d want 4/1", completed, busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || completed !== 32'd0 || succ !== 16'd0) begin errors++; $display("FAIL arst_immediate: got busy=%0d completed=%0d succ=%0d want 0/0/0", busy, completed, succ); end
        checks++; if (status !== ST_IDLE_OK || e_succ !== 2'd0) begin errors++; $display("FAIL arst_status: got status=%0d e_succ=%0d want 0/0", status, e_succ); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_no_done: got %0d want 0", done); end
        unit_done = 4'h0;
        #2 rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || completed !== 32'd0) begin errors++; $display("FAIL arst_after: got busy=%0d completed=%0d want 0/0", busy, completed); end
    endtask

    initial begin
        test_reset();
        test_full_success();
        test_excess_drop();
        test_abort();
        test_zero_target();
        test_start_in_run();
        test_err_limit();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
